inbuf_vc: RTL and testbench



---
 rtl/inbuf_vc_pkg.sv | 36 +++
 rtl/vc_fifo.sv | 72 +++++++
 rtl/inbuf_vc.sv | 119 +++++++++++
 tb/tb_inbuf_vc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/inbuf_vc_pkg.sv
// rtl/inbuf_vc_pkg.sv - shared widths and constants for the local-port input buffer
//
// Provides the shared width macros (`DATAW, `VCH, `VCHW) when the surrounding
// build has not already defined them, and derived localparams used by
// inbuf_vc and vc_fifo:
//   FLITW           flit width in bits (`DATAW+1)
//   NVC             number of virtual channels (`VCH+1)
//   VCW             VC index width (`VCHW+1)
//   INBUF_DEPTH_DEF default per-VC FIFO depth
//   rr_next()       round-robin successor of a VC index, wrapping at NVC

`ifndef DATAW
`define DATAW 7
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif

package inbuf_vc_pkg;

    localparam int FLITW           = `DATAW + 1;
    localparam int NVC             = `VCH + 1;
    localparam int VCW             = `VCHW + 1;
    localparam int INBUF_DEPTH_DEF = 4;

    function automatic logic [VCW-1:0] rr_next(input logic [VCW-1:0] sel);
        if (int'(sel) == NVC - 1)
            return '0;
        else
            return sel + VCW'(1);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single-VC synchronous flit FIFO
//
// Ports:
//   clk    in   rising-edge clock
//   rst_   in   asynchronous active-high reset; pointers and count to 0
//   push   in   write din at the tail (ignored when full)
//   pop    in   remove the head (ignored when empty)
//   din    in   flit to write
//   dout   out  current head flit (valid when !empty)
//   count  out  occupancy, PTRW+1 bits so DEPTH is representable
//   full   out  count == DEPTH
//   empty  out  count == 0

module vc_fifo
    import inbuf_vc_pkg::*;
#(
    parameter  int DEPTH = INBUF_DEPTH_DEF,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [FLITW-1:0] din,
    output logic [FLITW-1:0] dout,
    output logic [PTRW:0]    count,
    output logic             full,
    output logic             empty
);

    logic [FLITW-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wptr;
    logic [PTRW-1:0]  r_rptr;
    logic [PTRW:0]    r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == (PTRW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTRW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTRW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTRW+1)'(1);
                2'b01:   r_count <= r_count - (PTRW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inbuf_vc.sv
// rtl/inbuf_vc.sv - per-VC input flit buffer with round-robin output selection
//
// Optional build macro: INBUF_ERR_EN adds the sticky overflow flag err_ovf.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_    in   asynchronous active-high reset
//   idata   in   flit from the PE
//   ivalid  in   flit valid
//   ivch    in   target VC of the flit
//   irdy    out  per-VC space available (registered state only)
//   odata   out  head flit of the selected VC, 0 when ovalid=0
//   ovalid  out  some VC holds a flit
//   ovch    out  VC of odata, 0 when ovalid=0
//   ordy    in   switch stage takes the flit this cycle
//   err_ovf out  (INBUF_ERR_EN only) sticky overflow-attempt flag

module inbuf_vc
    import inbuf_vc_pkg::*;
#(
    parameter  int DEPTH = INBUF_DEPTH_DEF,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCW-1:0]   ivch,
    output logic [NVC-1:0]   irdy,
    output logic [FLITW-1:0] odata,
    output logic             ovalid,
    output logic [VCW-1:0]   ovch,
    input  logic             ordy
`ifdef INBUF_ERR_EN
    ,
    output logic             err_ovf
`endif
);

    logic [FLITW-1:0] w_dout  [NVC];
    logic [PTRW:0]    w_count [NVC];
    logic [NVC-1:0]   w_full;
    logic [NVC-1:0]   w_empty;
    logic [NVC-1:0]   w_space;
    logic [NVC-1:0]   w_push;
    logic [NVC-1:0]   w_pop;
    logic [VCW-1:0]   w_sel;
    logic             w_found;
    logic             w_ovalid;

    logic [VCW-1:0]   r_rr;

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        // A full FIFO refuses the push even if it is popped this cycle;
        // the freed slot becomes visible through count next cycle.
        assign w_space[v] = (w_count[v] != (PTRW+1)'(DEPTH));
        assign w_push[v]  = ivalid & (ivch == VCW'(v)) & ~w_full[v];
        assign w_pop[v]   = w_ovalid & ordy & (w_sel == VCW'(v));

        vc_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_  (rst_),
            .push  (w_push[v]),
            .pop   (w_pop[v]),
            .din   (idata),
            .dout  (w_dout[v]),
            .count (w_count[v]),
            .full  (w_full[v]),
            .empty (w_empty[v])
        );
    end

    assign irdy = rst_ ? '0 : w_space;

    // First non-empty VC at or after r_rr, wrapping around.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NVC; i++) begin
            int idx;
            idx = (int'(r_rr) + i) % NVC;
            if (!w_found && !w_empty[idx]) begin
                w_found = 1'b1;
                w_sel   = VCW'(idx);
            end
        end
    end

    assign w_ovalid = w_found & ~rst_;
    assign ovalid   = w_ovalid;
    assign odata    = w_ovalid ? w_dout[w_sel] : '0;
    assign ovch     = w_ovalid ? w_sel : '0;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_)
            r_rr <= '0;
        else if (w_ovalid && ordy)
            r_rr <= rr_next(w_sel);
    end

`ifdef INBUF_ERR_EN
    logic w_ovf;
    logic r_err_ovf;

    // A valid flit that no FIFO accepted is an overflow attempt.
    assign w_ovf   = ivalid & ~(|w_push);
    assign err_ovf = r_err_ovf;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_)
            r_err_ovf <= 1'b0;
        else if (w_ovf)
            r_err_ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_inbuf_vc.sv
// tb/tb_inbuf_vc.sv - directed self-checking bench for inbuf_vc

module tb_inbuf_vc;
    import inbuf_vc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_;
    logic [FLITW-1:0] idata;
    logic             ivalid;
    logic [VCW-1:0]   ivch;
    logic [NVC-1:0]   irdy;
    logic [FLITW-1:0] odata;
    logic             ovalid;
    logic [VCW-1:0]   ovch;
    logic             ordy;
`ifdef INBUF_ERR_EN
    logic             err_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inbuf_vc #(
        .DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .idata   (idata),
        .ivalid  (ivalid),
        .ivch    (ivch),
        .irdy    (irdy),
        .odata   (odata),
        .ovalid  (ovalid),
        .ovch    (ovch),
        .ordy    (ordy)
`ifdef INBUF_ERR_EN
        ,
        .err_ovf (err_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [VCW-1:0] vc, input logic [FLITW-1:0] d);
        ivalid = 1'b1;
        ivch   = vc;
        idata  = d;
        tick();
        ivalid = 1'b0;
    endtask

    initial begin
        logic [FLITW-1:0] rr_exp_d [4];
        logic [VCW-1:0]   rr_exp_v [4];
        int sent;
        int rd;
        int cyc;

        rst_   = 1'b1;
        ivalid = 1'b0;
        ivch   = '0;
        idata  = '0;
        ordy   = 1'b0;
        tick();
        tick();

        check("rst_irdy",   32'(irdy),   32'h0);
        check("rst_ovalid", 32'(ovalid), 32'h0);
        check("rst_odata",  32'(odata),  32'h0);
        check("rst_ovch",   32'(ovch),   32'h0);

        rst_ = 1'b0;
        #1;
        check("rel_irdy",   32'(irdy),   32'h3);
        check("rel_ovalid", 32'(ovalid), 32'h0);

        // Single flit on VC0 with ordy held high.
        ordy   = 1'b1;
        ivalid = 1'b1;
        ivch   = 1'b0;
        idata  = 8'h5A;
        check("single_nobypass", 32'(ovalid), 32'h0);
        tick();
        ivalid = 1'b0;
        check("single_ovalid", 32'(ovalid), 32'h1);
        check("single_ovch",   32'(ovch),   32'h0);
        check("single_odata",  32'(odata),  32'h5A);
        tick();
        check("single_gone", 32'(ovalid), 32'h0);

        // Fill VC1 with ordy low.
        ordy = 1'b0;
        for (int k = 1; k <= 4; k++)
            push(1'b1, FLITW'(k));
        check("fill_irdy1", 32'(irdy[1]), 32'h0);
        check("fill_irdy0", 32'(irdy[0]), 32'h1);
        check("fill_head",  32'(odata),   32'h1);
`ifdef INBUF_ERR_EN
        check("fill_err_before", 32'(err_ovf), 32'h0);
`endif
        push(1'b1, 8'h05);
`ifdef INBUF_ERR_EN
        check("fill_err_after", 32'(err_ovf), 32'h1);
`endif
        ordy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("fill_drain_ovch",  32'(ovch),  32'h1);
            check("fill_drain_odata", 32'(odata), 32'(k));
            tick();
        end
        check("fill_drain_empty", 32'(ovalid), 32'h0);

        // Round-robin between VC0 and VC1.
        ordy = 1'b0;
        push(1'b0, 8'hA0);
        push(1'b0, 8'hA1);
        push(1'b1, 8'hB0);
        push(1'b1, 8'hB1);
        rr_exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        rr_exp_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("rr_odata", 32'(odata), 32'(rr_exp_d[k]));
            check("rr_ovch",  32'(ovch),  32'(rr_exp_v[k]));
            tick();
        end
        ordy = 1'b0;
        check("rr_empty", 32'(ovalid), 32'h0);

        // Full VC0 popped while a push to it is attempted.
        for (int k = 0; k < 4; k++)
            push(1'b0, 8'hC0 + 8'(k));
        check("full_irdy", 32'(irdy), 32'h2);
        ordy   = 1'b1;
        ivalid = 1'b1;
        ivch   = 1'b0;
        idata  = 8'hEE;
        check("full_irdy_no_comb", 32'(irdy[0]), 32'h0);
        tick();
        ivalid = 1'b0;
        ordy   = 1'b0;
        check("full_irdy_next", 32'(irdy), 32'h3);
        ordy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            check("full_drain", 32'(odata), 32'hC0 + 32'(k));
            tick();
        end
        ordy = 1'b0;
        check("full_count3", 32'(ovalid), 32'h0);

        // Concurrent push/pop stream of 16 flits on VC1, ordy toggling.
        sent = 0;
        rd   = 0;
        cyc  = 0;
        while (rd < 16 && cyc < 200) begin
            ordy = (cyc % 2 == 0);
            if (sent < 16) begin
                ivalid = 1'b1;
                ivch   = 1'b1;
                idata  = 8'h30 + 8'(sent);
            end else begin
                ivalid = 1'b0;
            end
            if (ivalid && irdy[1])
                sent++;
            if (ovalid && ordy) begin
                check("stream_odata", 32'(odata), 32'h30 + 32'(rd));
                check("stream_ovch",  32'(ovch),  32'h1);
                rd++;
            end
            tick();
            cyc++;
        end
        ivalid = 1'b0;
        ordy   = 1'b0;
        check("stream_rd",    32'(rd),     32'd16);
        check("stream_sent",  32'(sent),   32'd16);
        check("stream_empty", 32'(ovalid), 32'h0);

        // Reset mid-stream with three flits buffered.
        push(1'b0, 8'hD0);
        push(1'b0, 8'hD1);
        push(1'b0, 8'hD2);
        check("mrst_pre_ovalid", 32'(ovalid), 32'h1);
        rst_ = 1'b1;
        #1;
        check("mrst_irdy",   32'(irdy),   32'h0);
        check("mrst_ovalid", 32'(ovalid), 32'h0);
        check("mrst_odata",  32'(odata),  32'h0);
        tick();
        rst_ = 1'b0;
        #1;
        check("mrst_rel_irdy",   32'(irdy),   32'h3);
        check("mrst_rel_ovalid", 32'(ovalid), 32'h0);
`ifdef INBUF_ERR_EN
        check("mrst_err_clear", 32'(err_ovf), 32'h0);
`endif
        push(1'b0, 8'h77);
        check("mrst_discard", 32'(odata), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
